// File: rtl/mouse_input_stage.sv
// Mouse input conditioning ahead of draw_mouse: bounds clamping, frame-synchronous
// position update, and per-button synchronise / debounce / click-pulse generation.

module mouse_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press,
    output logic pulse,
    output logic held
);
    // state | meaning
    // IDLE  | button released, next synchronised high level is a new click
    // LOCK  | lockout after a click; input ignored until the counter expires
    // HELD  | lockout over but button still down; wait for release
    typedef enum logic [1:0] {IDLE, LOCK, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // The parent captures click coordinates on exactly this condition.
    assign press = (state == IDLE) && s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= LOCK;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        held  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (cnt == CNT_LAST) begin
                        if (s2) begin
                            state <= HELD;
                        end else begin
                            state <= IDLE;
                            held  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module mouse_input_stage #(
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        vblnk_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left_click,
    output logic        right_click,
    output logic        left_held,
    output logic [11:0] click_x,
    output logic [11:0] click_y
);
    localparam logic [11:0] X_LIM = 12'(X_MAX);
    localparam logic [11:0] Y_LIM = 12'(Y_MAX);

    logic [11:0] cx;
    logic [11:0] cy;
    logic        vblnk_prev;
    logic        left_press;
    logic        right_press;
    logic        right_held;

    assign cx = (xpos_in > X_LIM) ? X_LIM : xpos_in;
    assign cy = (ypos_in > Y_LIM) ? Y_LIM : ypos_in;

    // Displayed position only moves at frame start so the cursor never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            xpos       <= '0;
            ypos       <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                xpos <= cx;
                ypos <= cy;
            end
        end
    end

    mouse_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_left (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (left_in),
        .press(left_press),
        .pulse(left_click),
        .held (left_held)
    );

    mouse_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_right (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (right_in),
        .press(right_press),
        .pulse(right_click),
        .held (right_held)
    );

    // Click coordinates use the live clamped position, not the frame-latched one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_x <= '0;
            click_y <= '0;
        end else if (left_press || right_press) begin
            click_x <= cx;
            click_y <= cy;
        end
    end

    logic unused_right_held;
    assign unused_right_held = right_held;
endmodule

// File: tb/tb_mouse_input_stage.sv
// Directed plus randomized bench for mouse_input_stage, checked against an
// edge-by-edge behavioural model built from timestamps rather than counters.

module tb_mouse_input_stage;
    localparam int D     = 8;
    localparam int XM    = 1023;
    localparam int YM    = 767;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] xpos_in = '0, ypos_in = '0;
    logic        left_in = 1'b0, right_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] xpos, ypos, click_x, click_y;
    logic        left_click, right_click, left_held;

    mouse_input_stage #(
        .X_MAX(XM), .Y_MAX(YM), .DEBOUNCE_CYCLES(D), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .left_in(left_in), .right_in(right_in), .vblnk_in(vblnk_in),
        .xpos(xpos), .ypos(ypos), .left_click(left_click), .right_click(right_click),
        .left_held(left_held), .click_x(click_x), .click_y(click_y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lc_seen = 0;

    // model: mode 0 = free, 1 = locked until end edge, 2 = waiting for release
    logic [11:0] m_xpos, m_ypos, m_cx, m_cy;
    logic        m_lc, m_rc, m_lh, m_vb_prev;
    logic        l_p1, l_p2, r_p1, r_p2;
    int          l_mode, r_mode, l_end, r_end;

    function automatic logic [11:0] clampv(input logic [11:0] v, input int mx);
        return (int'(v) > mx) ? 12'(mx) : v;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_xpos = '0; m_ypos = '0; m_cx = '0; m_cy = '0;
        m_lc = 0; m_rc = 0; m_lh = 0; m_vb_prev = 0;
        l_p1 = 0; l_p2 = 0; r_p1 = 0; r_p2 = 0;
        l_mode = 0; r_mode = 0; l_end = 0; r_end = 0;
    endtask

    task automatic btn(input logic s, input int mode_i, input int end_i,
                       output int mode_o, output int end_o, output logic fire);
        mode_o = mode_i; end_o = end_i; fire = 1'b0;
        if (mode_i == 0) begin
            if (s) begin fire = 1'b1; mode_o = 1; end_o = cyc + D; end
        end else if (mode_i == 1) begin
            if (cyc == end_i) mode_o = s ? 2 : 0;
        end else if (!s) begin
            mode_o = 0;
        end
    endtask

    task automatic model_edge();
        logic lf, rf;
        int   nm, ne;
        if (!rst_n) begin model_reset(); return; end
        btn(l_p2, l_mode, l_end, nm, ne, lf); l_mode = nm; l_end = ne;
        btn(r_p2, r_mode, r_end, nm, ne, rf); r_mode = nm; r_end = ne;
        if (lf || rf) begin m_cx = clampv(xpos_in, XM); m_cy = clampv(ypos_in, YM); end
        m_lc = lf; m_rc = rf; m_lh = (l_mode != 0);
        if (vblnk_in && !m_vb_prev) begin
            m_xpos = clampv(xpos_in, XM); m_ypos = clampv(ypos_in, YM);
        end
        m_vb_prev = vblnk_in;
        l_p2 = l_p1; l_p1 = left_in; r_p2 = r_p1; r_p1 = right_in;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".xpos"}, xpos, m_xpos);
        chk({tag, ".ypos"}, ypos, m_ypos);
        chk({tag, ".left_click"}, 12'(left_click), 12'(m_lc));
        chk({tag, ".right_click"}, 12'(right_click), 12'(m_rc));
        chk({tag, ".left_held"}, 12'(left_held), 12'(m_lh));
        chk({tag, ".click_x"}, click_x, m_cx);
        chk({tag, ".click_y"}, click_y, m_cy);
    endtask

    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model_edge();
            #1;
            if (left_click) lc_seen++;
            check_all(tag);
        end
    endtask

    initial begin
        // reset with random inputs
        model_reset();
        rst_n = 0;
        xpos_in = 12'($urandom); ypos_in = 12'($urandom);
        left_in = 1; right_in = 1; vblnk_in = 1;
        #3;
        check_all("rst");
        for (int i = 0; i < 4; i++) begin
            xpos_in = 12'($urandom); ypos_in = 12'($urandom); vblnk_in = 1'($urandom);
            step(1, "rst_hold");
        end
        left_in = 0; right_in = 0; vblnk_in = 0;
        rst_n = 1;
        step(4, "rst_rel");
        chk("rst_rel_xpos0", xpos, 12'd0);
        chk("rst_rel_click0", 12'(left_click), 12'd0);

        // clamp and frame latch
        xpos_in = 12'd1500; ypos_in = 12'd900;
        step(2, "clamp_low");
        chk("latch_wait_x", xpos, 12'd0);
        vblnk_in = 1;
        step(1, "clamp_rise");
        chk("latch_x", xpos, 12'd1023);
        chk("latch_y", ypos, 12'd767);
        xpos_in = 12'd100;
        step(3, "clamp_hold");
        chk("latch_hold_x", xpos, 12'd1023);
        vblnk_in = 0;
        step(1, "clamp_fall");
        vblnk_in = 1;
        step(1, "clamp_rise2");
        chk("latch2_x", xpos, 12'd100);

        // click latency
        xpos_in = 12'd200; ypos_in = 12'd300;
        left_in = 1;
        step(1, "lat_k");
        chk("lat_k_click", 12'(left_click), 12'd0);
        step(1, "lat_k1");
        chk("lat_k1_click", 12'(left_click), 12'd0);
        step(1, "lat_k2");
        chk("lat_k2_click", 12'(left_click), 12'd1);
        chk("lat_click_x", click_x, 12'd200);
        chk("lat_click_y", click_y, 12'd300);
        chk("lat_held", 12'(left_held), 12'd1);
        step(1, "lat_k3");
        chk("lat_k3_click", 12'(left_click), 12'd0);
        left_in = 0;
        step(14, "lat_rel");

        // bounce rejection
        lc_seen = 0;
        left_in = 1;
        step(1, "bnc_press");
        for (int i = 0; i < 6; i++) begin
            left_in = ~left_in;
            step(1, "bnc_tog");
        end
        left_in = 0;
        step(14, "bnc_rel");
        chk("bnc_pulses", 12'(lc_seen), 12'd1);

        // hold and re-press
        lc_seen = 0;
        left_in = 1;
        step(20, "hold");
        chk("hold_pulses", 12'(lc_seen), 12'd1);
        chk("hold_held", 12'(left_held), 12'd1);
        left_in = 0;
        step(4, "hold_rel");
        chk("hold_rel_held", 12'(left_held), 12'd0);
        left_in = 1;
        step(3, "repress");
        chk("repress_pulses", 12'(lc_seen), 12'd2);
        left_in = 0;
        step(14, "repress_rel");

        // simultaneous press, then reset mid-lockout
        xpos_in = 12'd4000; ypos_in = 12'd55;
        left_in = 1; right_in = 1;
        step(2, "sim_pre");
        step(1, "sim_fire");
        chk("sim_left", 12'(left_click), 12'd1);
        chk("sim_right", 12'(right_click), 12'd1);
        chk("sim_cx", click_x, 12'd1023);
        chk("sim_cy", click_y, 12'd55);
        step(2, "sim_lock");
        rst_n = 0;
        #2;
        model_reset();
        chk("rst_mid_held", 12'(left_held), 12'd0);
        check_all("rst_mid");
        left_in = 0; right_in = 0; vblnk_in = 0;
        step(2, "rst_mid_hold");
        rst_n = 1;
        step(2, "rst_mid_rel");
        left_in = 1;
        step(3, "post_rst_press");
        chk("post_rst_click", 12'(left_click), 12'd1);
        left_in = 0;
        step(14, "post_rst_rel");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) xpos_in = 12'($urandom_range(900, 1100));
            else xpos_in = 12'($urandom);
            if ($urandom_range(0, 3) == 0) ypos_in = 12'($urandom_range(700, 800));
            else ypos_in = 12'($urandom);
            if ($urandom_range(0, 19) == 0) vblnk_in = ~vblnk_in;
            if ($urandom_range(0, 5) == 0) left_in = ~left_in;
            if ($urandom_range(0, 5) == 0) right_in = ~right_in;
            step(1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
